// File: rtl/dbg_stim_pkg.sv
// Shared types for the debug stimulus player:
// command bytes, FSM encodings and the table entry.
package dbg_stim_pkg;

  localparam logic [7:0] CMD_WR   = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;
  localparam logic [7:0] CMD_STOP = 8'h03;
  localparam logic [7:0] CMD_STAT = 8'h04;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } play_st_t;

  typedef enum logic [1:0] {
    CMD,
    OP0,
    OP1,
    OP2
  } prs_st_t;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] hold;
  } entry_t;

endpackage

// File: rtl/dbg_ser_rx.sv
// Oversampled serial port: pin synchronizers, sck edge
// detect, byte assembly and status shift-out on miso.
module dbg_ser_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  input  logic       tx_load,
  input  logic [7:0] tx_byte,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame,
  output logic       miso
);

  logic [SYNC_STAGES-1:0] sck_sy;
  logic [SYNC_STAGES-1:0] cs_sy;
  logic [SYNC_STAGES-1:0] mosi_sy;
  logic       sck_q;
  logic       sck_s;
  logic       mosi_s;
  logic       rise;
  logic       fall;
  logic [2:0] cnt;
  logic [6:0] sh;
  logic [7:0] tx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sy  <= '0;
      cs_sy   <= '1;
      mosi_sy <= '0;
      sck_q   <= 1'b0;
    end else begin
      sck_sy  <= {sck_sy[SYNC_STAGES-2:0], sck};
      cs_sy   <= {cs_sy[SYNC_STAGES-2:0], cs_n};
      mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], mosi};
      sck_q   <= sck_s;
    end
  end

  assign sck_s  = sck_sy[SYNC_STAGES-1];
  assign mosi_s = mosi_sy[SYNC_STAGES-1];
  assign frame  = ~cs_sy[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_q;
  assign fall   = ~sck_s & sck_q;

  // byte strobe is combinational so the parser acts on the next edge
  assign byte_valid = frame & rise & (cnt == 3'd7);
  assign rx_byte    = {sh, mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sh  <= '0;
    end else if (!frame) begin
      cnt <= '0;
      sh  <= '0;
    end else if (rise) begin
      cnt <= cnt + 3'd1;
      sh  <= {sh[5:0], mosi_s};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx   <= '0;
      miso <= 1'b0;
    end else if (!frame) begin
      tx   <= '0;
      miso <= 1'b0;
    end else if (tx_load) begin
      tx <= tx_byte;
    end else if (fall) begin
      miso <= tx[7];
      tx   <= {tx[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/dbg_stim_player.sv
// Debug stimulus player: serial-loaded pattern table
// replayed onto stim_o with per-entry hold times.
module dbg_stim_player
  import dbg_stim_pkg::*;
#(
  parameter int DATA_W      = 4,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] stim_o,
  output logic              stim_oe,
  output logic              busy,
  output logic              done
);

  localparam int AW = $clog2(DEPTH);

  logic       bv;
  logic [7:0] rx;
  logic       frame;
  logic       tx_load;
  logic [7:0] stat;

  dbg_ser_rx #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .sck       (sck),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .tx_load   (tx_load),
    .tx_byte   (stat),
    .byte_valid(bv),
    .rx_byte   (rx),
    .frame     (frame),
    .miso      (miso)
  );

  prs_st_t           pst;
  prs_st_t           pst_d;
  logic [7:0]        cmd_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] data_q;
  logic              run_go;
  logic              stop_go;
  logic              wr_go;

  always_comb begin
    pst_d   = pst;
    run_go  = 1'b0;
    stop_go = 1'b0;
    wr_go   = 1'b0;
    tx_load = 1'b0;
    if (!frame) begin
      pst_d = CMD;
    end else if (bv) begin
      unique case (pst)
        CMD: begin
          stop_go = (rx == CMD_STOP);
          tx_load = (rx == CMD_STAT);
          pst_d   = stop_go ? CMD : OP0;
        end
        // unknown commands park here until the frame ends
        OP0: unique case (1'b1)
          cmd_q == CMD_WR:   pst_d = OP1;
          cmd_q == CMD_RUN: begin
            run_go = !busy;
            pst_d  = CMD;
          end
          cmd_q == CMD_STAT: pst_d = CMD;
          default:           pst_d = OP0;
        endcase
        OP1: pst_d = OP2;
        OP2: begin
          wr_go = !busy;
          pst_d = CMD;
        end
        default: pst_d = CMD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pst    <= CMD;
      cmd_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      pst <= pst_d;
      if (frame && bv) begin
        if (pst == CMD) cmd_q  <= rx;
        if (pst == OP0) addr_q <= rx[AW-1:0];
        if (pst == OP1) data_q <= rx[DATA_W-1:0];
      end
    end
  end

  entry_t mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_go) begin
      mem[addr_q] <= '{data: 8'(data_q), hold: rx};
    end
  end

  play_st_t      st;
  play_st_t      st_d;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_d;
  logic [AW-1:0] last_q;
  logic [AW-1:0] last_d;
  logic [7:0]    hcnt;
  logic [7:0]    hcnt_d;

  // N-1 wraps so that N=0 plays the whole table
  always_comb begin
    st_d   = st;
    ptr_d  = ptr;
    last_d = last_q;
    hcnt_d = hcnt;
    if (stop_go) begin
      st_d = IDLE;
    end else begin
      unique case (st)
        IDLE, DONE: if (run_go) begin
          st_d   = PLAY;
          ptr_d  = '0;
          last_d = rx[AW-1:0] - AW'(1);
          hcnt_d = mem[ptr_d].hold;
        end
        PLAY: begin
          if (hcnt != 8'd0) begin
            hcnt_d = hcnt - 8'd1;
          end else if (ptr == last_q) begin
            st_d = DONE;
          end else begin
            ptr_d  = ptr + AW'(1);
            hcnt_d = mem[ptr_d].hold;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      ptr    <= '0;
      last_q <= '0;
      hcnt   <= '0;
    end else begin
      st     <= st_d;
      ptr    <= ptr_d;
      last_q <= last_d;
      hcnt   <= hcnt_d;
    end
  end

  assign busy    = (st == PLAY);
  assign done    = (st == DONE);
  assign stim_oe = busy;
  assign stim_o  = busy ? mem[ptr].data[DATA_W-1:0] : '0;
  assign stat    = {busy, done, 2'b00, 4'(ptr)};

endmodule

// File: tb/tb_dbg_stim_player.sv
// Directed bench for dbg_stim_player: serial loads,
// cycle-exact playback, STOP, STAT and reset checks.
module tb_dbg_stim_player;

  localparam int H = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sck;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic [3:0] stim_o;
  logic       stim_oe;
  logic       busy;
  logic       done;

  int n_run  = 0;
  int n_fail = 0;
  int w;
  logic [7:0] r;

  dbg_stim_player #(
    .DATA_W     (4),
    .DEPTH      (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sck    (sck),
    .cs_n   (cs_n),
    .mosi   (mosi),
    .miso   (miso),
    .stim_o (stim_o),
    .stim_oe(stim_oe),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] b, input int nbits,
                      input bit open, output logic [7:0] q);
    q = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      tick(H);
      sck  = 1'b1;
      q[i] = miso;
      if (!(open && i == 0)) begin
        tick(H);
        sck = 1'b0;
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] q;
    xfer(b, 8, 1'b0, q);
  endtask

  task automatic cs_lo();
    cs_n = 1'b0;
    tick(H);
  endtask

  task automatic cs_hi();
    tick(H);
    cs_n = 1'b1;
    tick(H);
  endtask

  task automatic close_open();
    tick(H);
    sck = 1'b0;
    cs_hi();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d,
                    input logic [7:0] h);
    send(8'h01);
    send(a);
    send(d);
    send(h);
  endtask

  task automatic run_open(input logic [7:0] n);
    logic [7:0] q;
    cs_lo();
    send(8'h02);
    xfer(n, 8, 1'b1, q);
  endtask

  task automatic run_chk(input string tag, input int n,
                         input logic [63:0] vals);
    int lat = 0;
    while (!stim_oe && lat < 8) begin
      tick(1);
      lat++;
    end
    chk({tag, " lat"}, lat, 3);
    for (int k = 0; k < n; k++) begin
      if (k != 0) tick(1);
      chk({tag, " stim"}, {stim_oe, stim_o},
          {1'b1, vals[4*k +: 4]});
    end
    tick(1);
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " off"}, {stim_oe, stim_o}, 5'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    sck   = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    tick(3);
    chk("rst stim_o", stim_o, 4'h0);
    chk("rst oe", stim_oe, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst miso", miso, 1'b0);
    rst_n = 1'b1;
    tick(2);

    run_open(8'h00);
    run_chk("run0", 16, 64'h0);
    close_open();

    cs_lo();
    wr(8'h00, 8'h05, 8'h02);
    wr(8'h01, 8'h0A, 8'h00);
    wr(8'h02, 8'h0F, 8'h03);
    cs_hi();
    run_open(8'h03);
    run_chk("run3", 8, 64'hFFFF_A555);
    close_open();

    cs_lo();
    send(8'h04);
    xfer(8'h00, 8, 1'b0, r);
    cs_hi();
    chk("stat done", r, 8'h42);
    chk("miso idle", miso, 1'b0);

    cs_lo();
    wr(8'h00, 8'h05, 8'hFF);
    cs_hi();
    run_open(8'h03);
    tick(H);
    sck = 1'b0;
    xfer(8'h03, 7, 1'b0, r);
    mosi = 1'b1;
    tick(184);
    sck = 1'b1;
    chk("stop e1", {stim_oe, stim_o}, 5'h1A);
    tick(1);
    chk("stop f0", {stim_oe, stim_o}, 5'h1F);
    tick(1);
    chk("stop f1", {stim_oe, stim_o}, 5'h1F);
    tick(1);
    chk("stop off", {stim_oe, stim_o}, 5'h00);
    chk("stop done", done, 1'b0);
    chk("stop busy", busy, 1'b0);
    close_open();

    cs_lo();
    send(8'h04);
    xfer(8'h00, 8, 1'b0, r);
    cs_hi();
    chk("stat stop", r, 8'h02);

    cs_lo();
    wr(8'h00, 8'h05, 8'h02);
    wr(8'h13, 8'hC7, 8'h01);
    cs_hi();
    run_open(8'h04);
    run_chk("run4", 10, 64'h77_FFFF_A555);
    close_open();

    cs_lo();
    wr(8'h02, 8'h0F, 8'hFF);
    wr(8'h03, 8'h07, 8'hFF);
    cs_hi();
    cs_lo();
    send(8'h02);
    send(8'h04);
    send(8'h04);
    xfer(8'h00, 8, 1'b0, r);
    wr(8'h00, 8'h0C, 8'h00);
    cs_hi();
    chk("stat play", r, 8'h82);
    w = 0;
    while (!done && w < 1000) begin
      tick(1);
      w++;
    end
    chk("long done", done, 1'b1);

    cs_lo();
    send(8'h01);
    send(8'h00);
    send(8'h09);
    xfer(8'h00, 5, 1'b0, r);
    cs_hi();
    run_open(8'h01);
    run_chk("nowr", 3, 64'h555);
    close_open();

    cs_lo();
    send(8'h02);
    send(8'h04);
    cs_hi();
    tick(20);
    chk("pre rst busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst oe", stim_oe, 1'b0);
    chk("arst stim", stim_o, 4'h0);
    chk("arst busy", busy, 1'b0);
    chk("arst done", done, 1'b0);
    chk("arst miso", miso, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    run_open(8'h01);
    run_chk("clr", 1, 64'h0);
    close_open();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/dbg_stim_player.md
# dbg_stim_player

Debug stimulus player: the drive-side counterpart to the on-chip logic analyzer. The analyzer observes `buttom`/`led`; this block injects patterns instead. A host loads a small pattern table over a clk-oversampled 4-wire serial port (sck/cs_n/mosi/miso), then starts playback. Playback drives `stim_o` (muxed onto the `buttom` inputs upstream of the CPU bus) with per-entry hold times. It lets the team reproduce button sequences deterministically while the analyzer captures `BUS/ctrl` and `CPU/Reg/RegWe`.

## Interface
- `DATA_W`, 4: width of `stim_o`, matching `buttom`.
- `DEPTH`, 16: pattern table entries; power of two, at most 256.
- `SYNC_STAGES`, 2: synchronizer flops on sck, cs_n and mosi.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sck`  in  1  serial clock from the host, asynchronous to `clk`.
- `cs_n`  in  1  frame select, active low.
- `mosi`  in  1  serial data in, MSB first, sampled on sck rise.
- `miso`  out  1  serial data out, changes on sck fall.
- `stim_o`  out  DATA_W  injected pattern value.
- `stim_oe`  out  1  high while `stim_o` is to override `buttom`.
- `busy`  out  1  playback in progress.
- `done`  out  1  sticky; playback completed normally.

## Operation
- Frame: `cs_n` low, then 8-bit bytes. Byte 0 is the command; the following bytes are operands.
- `CMD_WR` (0x01): three operand bytes.
  - addr: the entry index is addr mod DEPTH.
  - data: only the low DATA_W bits are used.
  - hold: the entry is held for hold+1 clk cycles.
  - The entry is written when the hold byte completes.
  - Ignored while `busy`; the frame is still consumed.
- `CMD_RUN` (0x02): one operand N, the entry count. N=0 means DEPTH entries. Clears `done` and enters PLAY from ptr 0. Ignored while `busy`.
- `CMD_STOP` (0x03): no operands. Forces IDLE from any state, drives `stim_o`=0 and `stim_oe`=0, and clears `done`.
- `CMD_STAT` (0x04): during the next byte `miso` shifts out the status byte {busy, done, 2'b00, ptr[3:0]}. ptr is the low 4 bits of the play pointer.
- Unknown command: the rest of the frame is ignored.
- After the last operand the parser returns to the command state, so several commands can share one frame.
- `cs_n` rising mid-byte: the partial byte and any pending command are discarded. The player is unaffected.
- Player FSM:
  - IDLE → PLAY on RUN.
  - In PLAY, `stim_o`=mem[ptr].data and `stim_oe`=1. A hold counter loads mem[ptr].hold on entry and decrements each cycle. At 0, ptr increments.
  - After entry N-1 expires: PLAY → DONE, `stim_oe`=0, `stim_o`=0, `done`=1.
  - DONE → PLAY on RUN; DONE → IDLE on STOP.
- `busy` = (state==PLAY).
- Reset values:
  - `stim_o`=0, `stim_oe`=0, `busy`=0, `done`=0, `miso`=0.
  - Table cleared to zero; ptr=0; parser in the command state.
- Reset mid-frame or mid-playback: immediate return to the reset state. No output glitch beyond the asynchronous clear.

## Timing
- Synchronizer plus edge detect: an sck edge takes effect SYNC_STAGES+1 clk cycles after the pin edge.
- sck high and low times must each be at least SYNC_STAGES+2 clk cycles. `cs_n` setup and hold around the first and last sck edges must meet the same bound.
- A byte is complete on the clk cycle its 8th rising edge is detected. Command actions take effect on the following clk.
- RUN completes at cycle t. `stim_oe`=1 and `stim_o`=mem[0].data from t+1.
- An entry with hold h occupies exactly h+1 cycles.
- A whole run lasts sum(h_i+1) cycles. `done` rises on the first cycle after the last entry.
- `miso` updates on the detected sck fall, so bit 7 appears on the fall after the STAT byte's 8th rise. It returns to 0 when the frame ends.
- STOP versus hold expiry in the same cycle: STOP wins.

## Structure
- Package `dbg_stim_pkg` holds:
  - the CMD_* byte constants;
  - the player state enum {IDLE, PLAY, DONE};
  - the parser state enum {CMD, OP0, OP1, OP2};
  - the entry struct {data, hold}.
- Sub-module `dbg_ser_rx` contains the synchronizers, sck edge detection, the byte shift register with byte_valid strobe, and the miso shift-out.
- The top level holds the command parser, the table and the player FSM.

## Test plan
- Load three entries {5,h=2},{A,h=0},{F,h=3}, then RUN N=3 → stim_o reads 5,5,5,A,F,F,F,F. `stim_oe` is high for 8 cycles, then `done`=1 and `busy`=0.
- RUN N=0 with an all-zero table → 16 cycles of `stim_oe`=1 with `stim_o`=0, then `done`.
- STOP issued in the 2nd cycle of entry {F,h=3} → `stim_oe`=0 and `stim_o`=0 on the next clk. `done`=0; STAT returns 0x0y, where y is the current ptr.
- WR addr=0x13, data 0xC7, hold 1 → entry 3 = {7,h=1}; verified by a RUN N=4.
- WR issued during PLAY → table unchanged. `cs_n` raised after 5 bits of a WR byte → no write, and the next frame parses normally.
- STAT during playback of entry 2 → miso shifts out 0x82. Async `rst_n` pulse mid-playback → all outputs 0 immediately.
